// File: rtl/spectrum_axil_regs.sv
// AXI4-Lite register block for the spectrum analyzer: control/config registers, status with a
// sticky done flag and interrupt, and a post-incrementing read window into the magnitude-bin RAM.
module spectrum_axil_regs #(
  parameter int          ADDR_W  = 8,
  parameter int          BIN_AW  = 10,
  parameter logic [31:0] CORE_ID = 32'h5A00_0100
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              ctrl_enable,
  output logic              ctrl_start,
  output logic [15:0]       cfg_decim,
  input  logic              core_busy,
  input  logic              core_done,
  output logic [BIN_AW-1:0] bin_raddr,
  input  logic [31:0]       bin_rdata,
  output logic              irq
);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_DECIM  = 3'd2;
  localparam logic [2:0] OFF_IRQ    = 3'd3;
  localparam logic [2:0] OFF_BADDR  = 3'd4;
  localparam logic [2:0] OFF_BDATA  = 3'd5;
  localparam logic [2:0] OFF_ID     = 3'd7;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  wstate_t           r_wstate, w_wstate_next;
  rstate_t           r_rstate, w_rstate_next;
  logic              r_aw_have, r_w_have;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic              r_ctrl_enable, r_irq_en, r_ctrl_start, r_done_flag, r_irq;
  logic [15:0]       r_decim;
  logic [BIN_AW-1:0] r_bin_addr;

  logic              w_aw_hs, w_w_hs, w_wr_fire, w_wr_en, w_irq_clr;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata, w_wmask, w_rd_mux;
  logic [3:0]        w_wstrb;
  logic [2:0]        w_wr_sel, w_rd_sel;
  logic              w_wr_mapped, w_rd_mapped, w_ar_hs, w_rd_bin;
  logic [BIN_AW-1:0] w_bin_base, w_bin_next;
  logic              w_unused;

  // Write channel: each beat may arrive alone; the update fires once both are in hand.
  assign s_axi_awready = (r_wstate == W_IDLE) & ~r_aw_have;
  assign s_axi_wready  = (r_wstate == W_IDLE) & ~r_w_have;
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_bresp   = r_bresp;

  assign w_aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_w_hs      = s_axi_wvalid & s_axi_wready;
  assign w_wr_fire   = (r_wstate == W_IDLE) & (r_aw_have | w_aw_hs) & (r_w_have | w_w_hs);
  assign w_waddr     = r_aw_have ? r_awaddr : s_axi_awaddr;
  assign w_wdata     = r_w_have ? r_wdata : s_axi_wdata;
  assign w_wstrb     = r_w_have ? r_wstrb : s_axi_wstrb;
  assign w_wr_mapped = (w_waddr[ADDR_W-1:5] == '0);
  assign w_wr_sel    = w_waddr[4:2];
  assign w_wr_en     = w_wr_fire & w_wr_mapped;
  assign w_irq_clr   = w_wr_en & (w_wr_sel == OFF_IRQ) & w_wstrb[0] & w_wdata[0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
    assign w_wmask[gi*8 +: 8] = {8{w_wstrb[gi]}};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_next;
  end

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_fire) w_wstate_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else if (w_wr_fire) begin
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_bresp   <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) begin
        r_aw_have <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_have <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
    end
  end

  // Read channel: BIN_DATA takes an extra cycle for the RAM's registered output.
  assign s_axi_arready = (r_rstate == R_IDLE);
  assign s_axi_rvalid  = (r_rstate == R_DATA);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign bin_raddr     = r_bin_addr;

  assign w_ar_hs     = s_axi_arvalid & (r_rstate == R_IDLE);
  assign w_rd_mapped = (s_axi_araddr[ADDR_W-1:5] == '0);
  assign w_rd_sel    = s_axi_araddr[4:2];
  assign w_rd_bin    = w_ar_hs & w_rd_mapped & (w_rd_sel == OFF_BDATA);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_next;
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_next = w_rd_bin ? R_WAIT : R_DATA;
      R_WAIT:  w_rstate_next = R_DATA;
      R_DATA:  if (s_axi_rready) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_rd_mux = 32'd0;
    if (w_rd_mapped) begin
      case (w_rd_sel)
        OFF_CTRL:   w_rd_mux = {29'd0, r_irq_en, 1'b0, r_ctrl_enable};
        OFF_STATUS: w_rd_mux = {30'd0, r_done_flag, core_busy};
        OFF_DECIM:  w_rd_mux = {16'd0, r_decim};
        OFF_IRQ:    w_rd_mux = {31'd0, r_done_flag};
        OFF_BADDR:  w_rd_mux = {{(32-BIN_AW){1'b0}}, r_bin_addr};
        OFF_ID:     w_rd_mux = CORE_ID;
        default:    w_rd_mux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rdata <= 32'd0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs & ~w_rd_bin) begin
      r_rdata <= w_rd_mux;
      r_rresp <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rstate == R_WAIT) begin
      r_rdata <= bin_rdata;
      r_rresp <= RESP_OKAY;
    end
  end

  // A BIN_DATA read post-increments first; a same-cycle BIN_ADDR write then overrides it.
  assign w_bin_base = w_rd_bin ? (r_bin_addr + BIN_AW'(1)) : r_bin_addr;
  assign w_bin_next = (w_wr_en && (w_wr_sel == OFF_BADDR))
                    ? ((w_bin_base & ~w_wmask[BIN_AW-1:0]) | (w_wdata[BIN_AW-1:0] & w_wmask[BIN_AW-1:0]))
                    : w_bin_base;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ctrl_enable <= 1'b0;
      r_irq_en      <= 1'b0;
      r_ctrl_start  <= 1'b0;
      r_decim       <= 16'd1;
      r_done_flag   <= 1'b0;
      r_bin_addr    <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_ctrl_start <= 1'b0;
      r_irq        <= r_done_flag & r_irq_en;
      r_bin_addr   <= w_bin_next;
      if (core_done)      r_done_flag <= 1'b1;
      else if (w_irq_clr) r_done_flag <= 1'b0;
      if (w_wr_en) begin
        case (w_wr_sel)
          OFF_CTRL: if (w_wstrb[0]) begin
            r_ctrl_enable <= w_wdata[0];
            r_ctrl_start  <= w_wdata[1];
            r_irq_en      <= w_wdata[2];
          end
          OFF_DECIM: r_decim <= (r_decim & ~w_wmask[15:0]) | (w_wdata[15:0] & w_wmask[15:0]);
          default: ;
        endcase
      end
    end
  end

  assign ctrl_enable = r_ctrl_enable;
  assign ctrl_start  = r_ctrl_start;
  assign cfg_decim   = r_decim;
  assign irq         = r_irq;

  // Address byte-offset bits and unused data lanes are deliberately ignored.
  assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], w_wdata, w_wmask, w_wstrb};

endmodule

// File: doc/spectrum_axil_regs.md
# spectrum_axil_regs

AXI4-Lite responder (slave) giving the Zynq PS general-purpose master access to the spectrum-analyzer datapath. It holds the control and configuration registers, exposes status and a sticky done flag with an interrupt output, and provides a windowed read port into the magnitude-bin RAM. It sits between the PS M_AXI_GP0 interconnect and the FFT/magnitude pipeline in the PL, and is the target of the PS write_data/read_data transactions in the top-level bench.

## Interface
- ADDR_W, 8: AXI address width; only bits [4:2] are decoded.
- BIN_AW, 10: magnitude RAM address width, giving 2^BIN_AW bins.
- CORE_ID, 32'h5A_0001_00: constant returned at offset 0x1C.
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  ADDR_W; s_axi_awvalid  in  1; s_axi_awready  out  1: write address channel.
- s_axi_wdata  in  32; s_axi_wstrb  in  4; s_axi_wvalid  in  1; s_axi_wready  out  1: write data channel.
- s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1: write response channel.
- s_axi_araddr  in  ADDR_W; s_axi_arvalid  in  1; s_axi_arready  out  1: read address channel.
- s_axi_rdata  out  32; s_axi_rresp  out  2; s_axi_rvalid  out  1; s_axi_rready  in  1: read data channel.
- ctrl_enable  out  1: datapath enable (CTRL[0]).
- ctrl_start  out  1: one-cycle start pulse.
- cfg_decim  out  16: decimation factor.
- core_busy  in  1: datapath busy level.
- core_done  in  1: one-cycle frame-complete pulse.
- bin_raddr  out  BIN_AW: magnitude RAM read address.
- bin_rdata  in  32: RAM data, valid 1 cycle after bin_raddr.
- irq  out  1: level interrupt, done_flag AND irq_en.

## Operation
- Register map. Offsets 0x00..0x1C are decoded; all other offsets are unmapped.
  - 0x00 CTRL, RW: [0] enable, [1] start (write-1 pulses ctrl_start, reads 0), [2] irq_en.
  - 0x04 STATUS, RO: [0] core_busy, [1] done_flag.
  - 0x08 DECIM, RW [15:0].
  - 0x0C IRQ, W1C: [0] done_flag.
  - 0x10 BIN_ADDR, RW [BIN_AW-1:0].
  - 0x14 BIN_DATA, RO: bin_rdata at BIN_ADDR; each read post-increments BIN_ADDR, wrapping from 2^BIN_AW-1 to 0.
  - 0x18 reserved, reads 0, writes ignored, OKAY.
  - 0x1C ID, RO CORE_ID.
- Write strobes are honoured per byte on RW registers. A bit written to W1C clears only when its byte strobe is set. Writes to RO registers are ignored and return OKAY.
- Unmapped addresses (awaddr/araddr[ADDR_W-1:5] != 0) return SLVERR (2'b10) with rdata 0. Mapped addresses return OKAY. Address bits [1:0] are ignored.
- done_flag is set by core_done and cleared by W1C. Set wins when both occur in the same cycle.
- Write FSM: W_IDLE -> W_RESP -> W_IDLE.
  - AW and W are accepted independently in any order; each ready deasserts once its beat is captured.
  - When both are held, the register update occurs on that cycle, then bvalid=1.
  - bvalid is held until bready; ready signals reassert the cycle after the B handshake.
  - One outstanding write.
- Read FSM: R_IDLE -> R_WAIT (BIN_DATA only) -> R_DATA -> R_IDLE.
  - arready=1 only in R_IDLE.
  - rdata/rresp are stable while rvalid=1 and not rready.
  - One outstanding read.
- Read and write channels run concurrently. A BIN_ADDR write and a BIN_DATA read landing in the same cycle are ordered as: the read uses the old BIN_ADDR, post-increments, then the write overrides.

## Timing
- Reset values: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; ctrl_enable=0; ctrl_start=0; irq=0; cfg_decim=16'd1; bin_raddr=0; done_flag=0.
- Write: bvalid asserts 1 cycle after the later of the AW/W handshakes. Register outputs update on the same edge as bvalid. ctrl_start is high for exactly that one cycle.
- Read, register: rvalid asserts 1 cycle after the AR handshake.
- Read, BIN_DATA: rvalid asserts 2 cycles after the AR handshake. bin_raddr is driven in R_IDLE from BIN_ADDR, and the RAM data is registered into rdata.
- irq is registered: it follows done_flag/irq_en 1 cycle later.
- areset mid-transaction aborts all channels. No B or R beat is produced for the aborted transaction.

## Test plan
- Reset, then read 0x1C -> rdata=CORE_ID, rresp=0; read 0x08 -> 0x00000001.
- Write 0x08=0xABCD1234 with wstrb=4'b0001 -> cfg_decim=16'h0034, bresp=0. Present W 3 cycles before AW -> single B after AW, with correct update.
- Write 0x00=0x7 -> ctrl_enable=1, ctrl_start high for 1 cycle, CTRL reads 0x5. Pulse core_done -> STATUS[1]=1, irq=1. Write 0x0C=1 in the same cycle as another core_done -> flag remains 1. Write 0x0C=1 alone -> irq=0.
- Preload RAM with bin[i]=i*3, write BIN_ADDR=2^BIN_AW-2, read BIN_DATA 3 times -> 0x0BFA, 0x0BFD, 0x0000 (for BIN_AW=10). BIN_ADDR reads 1 afterwards.
- Read 0x40 and write 0x40 -> rresp=bresp=2'b10, rdata=0, no register changes. Hold rready=0 for 5 cycles -> rdata stable and arready=0.
- Assert areset while bvalid=1 -> bvalid=0 and ready signals =1 immediately. A subsequent write completes normally.
